spi_cfg_ctrl: RTL and testbench
===============================

// Module: spi_cfg_ctrl
// PURPOSE
//  SPI-mode-0, write-only configuration controller for tt_um_uwasic_onboarding_arnav_shah.
//  Samples external SCLK/COPI/nCS (driven from ui_in) in the clk domain.
//  Decodes 16-bit frames and sequences writes into the five config registers
//  that drive the output-enable and PWM datapath.
//  Sits between the dedicated inputs and the PWM peripheral; is the only writer of its config.
// PARAMETERS
//  SYNC_STAGES  2   flops in each input synchroniser (>=2)
//  MAX_ADDR     4   highest writable register address; higher addresses are discarded
//  FRAME_BITS   16  bits per valid frame: [15]=R/W (1=write), [14:8]=addr, [7:0]=data
// PORTS
//  clk              in   1  system clock
//  rst_n            in   1  asynchronous active-low reset
//  sclk             in   1  SPI clock, asynchronous to clk
//  copi             in   1  SPI data in, MSB first, sampled on SCLK rising edge
//  ncs              in   1  SPI chip select, active low, asynchronous
//  en_reg_out_7_0   out  8  addr 0x00: output enable, uo_out[7:0]
//  en_reg_out_15_8  out  8  addr 0x01: output enable, uio_out[7:0]
//  en_reg_pwm_7_0   out  8  addr 0x02: PWM select, uo_out[7:0]
//  en_reg_pwm_15_8  out  8  addr 0x03: PWM select, uio_out[7:0]
//  pwm_duty_cycle   out  8  addr 0x04: PWM duty (0x00=0%, 0xFF=100%)
//  wr_pulse         out  1  high for exactly one clk when a register is committed
//  frame_err        out  1  high for one clk when a frame is discarded
// BEHAVIOUR
//  Reset (async assert, sync deassert inside):
//   - all config registers, wr_pulse and frame_err = 0; FSM = IDLE
//   - sync chains preset: sclk=0, copi=0, ncs=1
//  Edge detection: on the synchronised signals only; sclk_rise, ncs_fall, ncs_rise are 1-clk pulses.
//  FSM:
//   IDLE:   on ncs_fall -> SHIFT; clear shift_reg and bit_cnt
//   SHIFT:  each sclk_rise shifts copi into shift_reg LSB; bit_cnt increments and saturates at FRAME_BITS+1.
//           On ncs_rise -> COMMIT if bit_cnt==FRAME_BITS && shift_reg[15]==1 && addr<=MAX_ADDR; otherwise -> IDLE and pulse frame_err.
//   COMMIT: one clk; wr_pulse=1; the addressed register loads shift_reg[7:0] on the clk edge leaving COMMIT -> IDLE.
//  Latency:
//   - raw ncs rise -> wr_pulse: SYNC_STAGES+1 clk
//   - new register value visible the clk after wr_pulse
//  Read frames (bit15=0) are discarded without a frame_err pulse; no register changes.
//  Short (<16) or long (>16) frames: discarded, frame_err pulses, no register changes.
//  sclk_rise and ncs_rise in the same clk: ncs_rise wins; that sclk edge is dropped.
//  ncs low at reset release: ignored until a fresh ncs_fall is seen.
//  Reset mid-frame: frame is lost; registers go to 0 immediately.
//  Timing contract: SCLK high and low phases each >= SYNC_STAGES+1 clk periods;
//   nCS high >= SYNC_STAGES+2 clk periods between frames.
//  Registers hold their value indefinitely between writes; writes are byte-wide with no partial update.
// STRUCTURE
//  Package spi_cfg_pkg:
//   - ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_DUTY=4
//   - FRAME_BITS
//   - state encoding {IDLE, SHIFT, COMMIT}
//  Sub-module spi_in_sync: parameterised SYNC_STAGES synchroniser plus rise/fall detect;
//   instantiated once each for sclk, copi and ncs (copi uses the level only).
//  Top holds the FSM, shift register, bit counter and register file.
// TESTING
//  1. Reset, then write 0x80_FF (addr 0, data 0xFF) -> en_reg_out_7_0=0xFF, one wr_pulse, others stay 0.
//  2. Write 0x84_80 -> pwm_duty_cycle=0x80; a following write 0x84_00 -> pwm_duty_cycle=0x00.
//  3. Write to addr 0x05 (0x85_AA) -> no register change, frame_err=1 for one clk.
//  4. 15-bit frame, then a 17-bit frame to addr 1 -> both discarded, frame_err twice, en_reg_out_15_8=0.
//  5. Read frame 0x02_55 -> no change, no wr_pulse, no frame_err.
//  6. Assert rst_n low after 8 bits of 0x83_3C, then send a full frame 0x83_3C -> all regs 0 at reset;
//     en_reg_pwm_15_8=0x3C after the clean frame.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared constants and FSM encoding for the SPI configuration controller.
// Register addresses and frame geometry live here so the top and any peer block agree.
package spi_cfg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'd0;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'd1;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'd2;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'd3;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with 1-clk rise/fall pulses.
// Edges are suppressed until the chain holds only post-reset samples of the pin.
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   q_prev;
  logic [SYNC_STAGES:0]   rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain  <= {SYNC_STAGES{RST_VAL}};
      q_prev <= RST_VAL;
      rdy    <= '0;
    end else begin
      chain  <= {chain[SYNC_STAGES-2:0], d};
      q_prev <= chain[SYNC_STAGES-1];
      rdy    <= {rdy[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // A pin held at its non-reset level through reset must not look like an edge.
  assign q    = chain[SYNC_STAGES-1];
  assign rise = rdy[SYNC_STAGES] &  q & ~q_prev;
  assign fall = rdy[SYNC_STAGES] & ~q &  q_prev;

endmodule

// File: rtl/spi_cfg_ctrl.sv
// SPI mode-0 write-only configuration controller: decodes 16-bit frames sampled
// in the clk domain and commits them into five byte-wide config registers.
module spi_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse,
  output logic       frame_err
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic [1:0] rst_sync;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  logic sclk_q, sclk_rise, sclk_fall;
  logic copi_q, copi_rise, copi_fall;
  logic ncs_q,  ncs_rise,  ncs_fall;

  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_int_n), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_int_n), .d(copi), .q(copi_q), .rise(copi_rise), .fall(copi_fall)
  );
  spi_in_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_int_n), .d(ncs), .q(ncs_q), .rise(ncs_rise), .fall(ncs_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_q, sclk_fall, copi_rise, copi_fall, ncs_q};

  state_t                  state, state_nxt;
  logic [FRAME_BITS-1:0]   shift_reg;
  logic [CNT_W-1:0]        bit_cnt;
  logic [ADDR_W-1:0]       frame_addr;
  logic                    frame_full, frame_wr, addr_ok;
  logic                    clr_frame, shift_en, err_nxt;

  assign frame_addr = shift_reg[FRAME_BITS-2 -: ADDR_W];
  assign frame_full = (bit_cnt == CNT_FULL);
  assign frame_wr   = shift_reg[FRAME_BITS-1];
  assign addr_ok    = (int'(frame_addr) <= MAX_ADDR);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_frame = 1'b0;
    shift_en  = 1'b0;
    err_nxt   = 1'b0;
    wr_pulse  = 1'b0;
    case (state)
      IDLE: begin
        if (ncs_fall) begin
          state_nxt = SHIFT;
          clr_frame = 1'b1;
        end
      end
      SHIFT: begin
        // ncs_rise takes priority so a coincident sclk edge is dropped.
        if (ncs_rise) begin
          if (frame_full && frame_wr && addr_ok) begin
            state_nxt = COMMIT;
          end else begin
            state_nxt = IDLE;
            err_nxt   = !(frame_full && !frame_wr);
          end
        end else if (sclk_rise) begin
          shift_en = 1'b1;
        end
      end
      COMMIT: begin
        wr_pulse  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr_frame)     shift_reg <= '0;
    else if (shift_en) shift_reg <= {shift_reg[FRAME_BITS-2:0], copi_q};
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      bit_cnt   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err_nxt;
      if (clr_frame)                         bit_cnt <= '0;
      else if (shift_en && bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else if (wr_pulse) begin
      case (frame_addr)
        ADDR_EN_OUT_LO: en_reg_out_7_0  <= shift_reg[7:0];
        ADDR_EN_OUT_HI: en_reg_out_15_8 <= shift_reg[7:0];
        ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= shift_reg[7:0];
        ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= shift_reg[7:0];
        ADDR_DUTY:      pwm_duty_cycle  <= shift_reg[7:0];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_ctrl.sv
// Scoreboard bench for spi_cfg_ctrl: directed frames plus randomized frames against
// a frame-level reference model; a negedge monitor checks pulses, latency and registers.
module tb_spi_cfg_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse, frame_err;

  spi_cfg_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(4)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_wr;
    int         addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model [5];
  int         checks   = 0;
  int         failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: compares registers every cycle and consumes one expected event per pulse.
  initial begin
    bit   apply;
    exp_t cur, e;
    apply = 1'b0;
    foreach (model[i]) model[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        foreach (model[i]) model[i] = 8'h00;
        apply = 1'b0;
        check("reset_regs", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0,
                             en_reg_pwm_15_8, pwm_duty_cycle}, 64'h0);
        check("reset_flags", {wr_pulse, frame_err}, 64'h0);
        continue;
      end
      if (apply) begin
        model[cur.addr] = cur.data;
        apply = 1'b0;
      end
      check("regs", {en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle},
                    {model[0], model[1], model[2], model[3], model[4]});
      if (wr_pulse || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {wr_pulse, frame_err}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {wr_pulse, frame_err}, e.is_wr ? 64'h2 : 64'h1);
          check("pulse_cycle", cyc, e.cyc);
          if (wr_pulse && e.is_wr) begin
            cur   = e;
            apply = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic shift_bits(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = bits[i];
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
  endtask

  // Reference rules: only exact 16-bit frames act; writes above addr 4 and bad lengths flag an error.
  task automatic send_frame(input logic [31:0] bits, input int n);
    exp_t e;
    ncs = 1'b0;
    tick(HALF);
    shift_bits(bits, n);
    tick(HALF);
    ncs = 1'b1;
    e.cyc  = cyc + SYNC_STAGES + 1;
    e.addr = int'(bits[14:8]);
    e.data = bits[7:0];
    if (n == 16 && bits[15] == 1'b0) begin
      // read frame: silently ignored
    end else if (n == 16 && e.addr <= 4) begin
      e.is_wr = 1'b1;
      exp_q.push_back(e);
    end else begin
      e.is_wr = 1'b0;
      exp_q.push_back(e);
    end
    tick(3 * SYNC_STAGES + 4);
  endtask

  initial begin
    int         n, sel;
    logic [31:0] b;

    rst_n = 1'b0;
    tick(5);
    rst_n = 1'b1;
    tick(10);

    send_frame(32'h80FF, 16);
    send_frame(32'h8480, 16);
    send_frame(32'h8400, 16);
    send_frame(32'h85AA, 16);
    send_frame(32'h815A, 15);
    send_frame(32'h1815A, 17);
    send_frame(32'h0255, 16);

    // Reset mid-frame with ncs still low at release: the tail of the frame must be ignored.
    ncs = 1'b0;
    tick(HALF);
    shift_bits(32'h83, 8);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    shift_bits(32'h3C, 8);
    tick(HALF);
    ncs = 1'b1;
    tick(12);
    send_frame(32'h833C, 16);

    for (int k = 0; k < 40; k++) begin
      sel = int'($urandom_range(0, 9));
      n   = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      b   = $urandom;
      b[15]   = ($urandom_range(0, 3) != 0);
      b[14:8] = 7'($urandom_range(0, 7));
      send_frame(b, n);
    end

    tick(20);
    check("pending_events", exp_q.size(), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
